id_ex_alu_issue: RTL and testbench
==================================

ID_EX_ALU_ISSUE -- requirements
Module: id_ex_alu_issue

Interface
REQ-001 Parameter: DATA_W, 32, operand/result width; only 32 is supported.
REQ-002 Port: clk  in  1  rising-edge clock; the block has one clock.
REQ-003 Port: rst_n  in  1  reset, asynchronous, active-low.
REQ-004 Port: in_valid  in  1  decoded instruction present from ID.
REQ-005 Port: in_ready  out  1  block accepts ID instruction this cycle.
REQ-006 Port: rs1_data, rs2_data  in  32 each  register-file read data.
REQ-007 Port: rs1_addr, rs2_addr, rd_addr  in  5 each  source/destination register indices.
REQ-008 Port: imm  in  32  sign-extended immediate; use_imm  in  1  B operand is imm.
REQ-009 Port: alu_class  in  2  00 addr-add, 01 branch-compare, 10 arith, 11 LUI pass.
REQ-010 Port: funct3  in  3; funct7b5  in  1  instruction bit 30.
REQ-011 Port: flush  in  1  kill held/incoming instruction; ex_stall  in  1  EX cannot consume.
REQ-012 Port: exm_wr  in  1, exm_rd  in  5, exm_data  in  32  EX/MEM forwarding source.
REQ-013 Port: mwb_wr  in  1, mwb_rd  in  5, mwb_data  in  32  MEM/WB forwarding source.
REQ-014 Port: out_valid  out  1, out_rd  out  5, out_illegal  out  1  issued instruction status.
REQ-015 Port: alu_a, alu_b  out  32; alu_op  out  4  ALU operands and operation code.

Function
REQ-016 in_ready SHALL equal (!out_valid || !ex_stall) && !flush, combinationally.
REQ-017 On in_valid && in_ready, all ID fields and decoded alu_op SHALL register next edge and out_valid SHALL be set.
REQ-018 With out_valid && ex_stall && !flush, registered contents SHALL hold unchanged.
REQ-019 With !in_valid and !ex_stall and !flush, out_valid SHALL clear next edge (bubble).
REQ-020 flush SHALL clear out_valid next edge, overriding capture and hold; simultaneous in_valid is discarded.
REQ-021 Decode: class 00 -> 0010 ADD; 01 -> 0110 SUB; 11 -> 0010 ADD with alu_a = 0, alu_b = imm.
REQ-022 Class 10 decode by funct3: 000 ADD, or SUB (0110) when funct7b5 && !use_imm; 001 SLL 1101; 010/011 SLT 0111; 101 SRL 1110, or SRA 1000 when funct7b5; 110 OR 0001; 111 AND 0000.
REQ-023 Class 10 funct3 100 (XOR, unsupported) SHALL issue alu_op 0000 and out_illegal = 1; otherwise out_illegal = 0.
REQ-024 Forwarding SHALL be combinational on the held register contents, so a stalled instruction picks up newer producers.
REQ-025 Source match priority: exm_wr && exm_rd == rs, then mwb_wr && mwb_rd == rs, else registered rsX_data.
REQ-026 Register index 0 SHALL never match a forwarding source; its operand is the registered value.
REQ-027 alu_a = forwarded rs1 except class 11; alu_b = registered imm when use_imm, else forwarded rs2.
REQ-028 Latency: ID accept to valid ALU operands = 1 cycle; alu_op is registered, never combinational from inputs.

Reset
REQ-029 rst_n low SHALL asynchronously force out_valid = 0, out_illegal = 0, alu_op = 0000, out_rd = 0, and all stored fields to 0.
REQ-030 Reset mid-stall SHALL drop the held instruction; after release in_ready = 1 in the first cycle.

Structure
REQ-031 Shared package riscv_pkg SHALL hold the AluOp constants (AND, OR, ADD, SUB, SLT, NOR, SLL, SRL, SRA) and the alu_class encodings.
REQ-032 The combinational alu_class/funct3/funct7b5 -> alu_op and illegal decode SHALL be a sub-module alu_op_decode.
REQ-033 The pipeline register and forwarding muxes SHALL be in id_ex_alu_issue; the expected size is 150-250 RTL lines.

Verification
REQ-034 Accept class 10, funct3 000, funct7b5 = 1, use_imm = 0, rs1 = 7, rs2 = 3 -> next cycle out_valid = 1, alu_op = 0110, alu_a = 7, alu_b = 3.
REQ-035 rs1_addr = 5, exm_wr = 1, exm_rd = 5, exm_data = 0xAA, mwb_rd = 5, mwb_data = 0xBB -> alu_a = 0xAA; with exm_wr = 0 -> alu_a = 0xBB.
REQ-036 rs2_addr = 0, exm_wr = 1, exm_rd = 0, exm_data = 0x55, registered rs2 = 0 -> alu_b = 0.
REQ-037 out_valid = 1, ex_stall = 1 for 3 cycles with in_valid = 1 -> in_ready = 0, outputs held; mwb data change during the stall is reflected on alu_a.
REQ-038 flush together with in_valid = 1 -> next cycle out_valid = 0; class 10, funct3 100 -> out_illegal = 1, alu_op = 0000.
REQ-039 Assert rst_n = 0 asynchronously mid-stall -> out_valid = 0 immediately, before the next clock edge.

Source files
------------

// File: rtl/riscv_pkg.sv
// riscv_pkg: shared ALU op codes, ALU class encodings and the ID/EX issue record
package riscv_pkg;
  localparam int XLEN = 32;
  typedef enum logic [3:0] {
    ALU_AND = 4'b0000,
    ALU_OR  = 4'b0001,
    ALU_ADD = 4'b0010,
    ALU_SUB = 4'b0110,
    ALU_SLT = 4'b0111,
    ALU_SRA = 4'b1000,
    ALU_NOR = 4'b1100,
    ALU_SLL = 4'b1101,
    ALU_SRL = 4'b1110
  } alu_op_e;
  typedef enum logic [1:0] {
    CLS_ADDR   = 2'b00,
    CLS_BRANCH = 2'b01,
    CLS_ARITH  = 2'b10,
    CLS_LUI    = 2'b11
  } alu_class_e;
  typedef struct packed {
    logic [4:0]      rd;
    logic [4:0]      rs1_addr;
    logic [4:0]      rs2_addr;
    logic [XLEN-1:0] rs1_data;
    logic [XLEN-1:0] rs2_data;
    logic [XLEN-1:0] imm;
    logic            use_imm;
    logic            lui;
    logic            illegal;
    alu_op_e         op;
  } issue_t;
endpackage

// File: rtl/alu_op_decode.sv
// alu_op_decode: combinational alu_class/funct3/funct7b5 to ALU op and illegal flag
module alu_op_decode
  import riscv_pkg::*;
(
  input  alu_class_e alu_class_i,
  input  logic [2:0] funct3_i,
  input  logic       funct7b5_i,
  input  logic       use_imm_i,
  output alu_op_e    alu_op_o,
  output logic       illegal_o
);
  alu_op_e arith_op;
  // funct3 decode for the arithmetic class; XOR has no ALU op and falls to AND
  always_comb begin
    arith_op = ALU_AND;
    case (funct3_i)
      3'b000:  arith_op = (funct7b5_i && !use_imm_i) ? ALU_SUB : ALU_ADD;
      3'b001:  arith_op = ALU_SLL;
      3'b010,
      3'b011:  arith_op = ALU_SLT;
      3'b101:  arith_op = funct7b5_i ? ALU_SRA : ALU_SRL;
      3'b110:  arith_op = ALU_OR;
      default: arith_op = ALU_AND;
    endcase
  end
  // class selects the final op; only arithmetic XOR is flagged illegal
  always_comb begin
    alu_op_o  = (alu_class_i == CLS_ARITH)  ? arith_op :
                (alu_class_i == CLS_BRANCH) ? ALU_SUB  : ALU_ADD;
    illegal_o = (alu_class_i == CLS_ARITH) && (funct3_i == 3'b100);
  end
endmodule

// File: rtl/id_ex_alu_issue.sv
// id_ex_alu_issue: ID/EX pipeline register with registered ALU op and live operand forwarding
module id_ex_alu_issue
  import riscv_pkg::*;
#(
  parameter int DATA_W = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [DATA_W-1:0] rs1_data,
  input  logic [DATA_W-1:0] rs2_data,
  input  logic [4:0]        rs1_addr,
  input  logic [4:0]        rs2_addr,
  input  logic [4:0]        rd_addr,
  input  logic [DATA_W-1:0] imm,
  input  logic              use_imm,
  input  logic [1:0]        alu_class,
  input  logic [2:0]        funct3,
  input  logic              funct7b5,
  input  logic              flush,
  input  logic              ex_stall,
  input  logic              exm_wr,
  input  logic [4:0]        exm_rd,
  input  logic [DATA_W-1:0] exm_data,
  input  logic              mwb_wr,
  input  logic [4:0]        mwb_rd,
  input  logic [DATA_W-1:0] mwb_data,
  output logic              out_valid,
  output logic [4:0]        out_rd,
  output logic              out_illegal,
  output logic [DATA_W-1:0] alu_a,
  output logic [DATA_W-1:0] alu_b,
  output logic [3:0]        alu_op
);
  issue_t            ins_q, ins_d;
  logic              valid_q, valid_d;
  logic              accept;
  alu_op_e           dec_op;
  logic              dec_ill;
  logic [DATA_W-1:0] rs1_fwd, rs2_fwd;

  alu_op_decode u_dec (
    .alu_class_i (alu_class_e'(alu_class)),
    .funct3_i    (funct3),
    .funct7b5_i  (funct7b5),
    .use_imm_i   (use_imm),
    .alu_op_o    (dec_op),
    .illegal_o   (dec_ill)
  );

  assign in_ready = (!valid_q || !ex_stall) && !flush;
  assign accept   = in_valid && in_ready;

  // flush kills, accept loads, a stalled valid holds, anything else bubbles
  always_comb begin
    valid_d = flush ? 1'b0 : accept ? 1'b1 : (valid_q && ex_stall);
    ins_d   = accept ? '{rd: rd_addr, rs1_addr: rs1_addr, rs2_addr: rs2_addr,
                         rs1_data: rs1_data, rs2_data: rs2_data, imm: imm,
                         use_imm: use_imm, lui: alu_class == CLS_LUI,
                         illegal: dec_ill, op: dec_op}
                     : ins_q;
  end

  // pipeline register; reset drops any held instruction immediately
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      ins_q   <= '0;
    end else begin
      valid_q <= valid_d;
      ins_q   <= ins_d;
    end
  end

  // forwarding reads the held indices every cycle so a stalled op sees newer producers; x0 never forwards
  always_comb begin
    rs1_fwd = (ins_q.rs1_addr != 5'd0 && exm_wr && exm_rd == ins_q.rs1_addr) ? exm_data :
              (ins_q.rs1_addr != 5'd0 && mwb_wr && mwb_rd == ins_q.rs1_addr) ? mwb_data :
              ins_q.rs1_data;
    rs2_fwd = (ins_q.rs2_addr != 5'd0 && exm_wr && exm_rd == ins_q.rs2_addr) ? exm_data :
              (ins_q.rs2_addr != 5'd0 && mwb_wr && mwb_rd == ins_q.rs2_addr) ? mwb_data :
              ins_q.rs2_data;
  end

  assign out_valid   = valid_q;
  assign out_rd      = ins_q.rd;
  assign out_illegal = ins_q.illegal;
  assign alu_op      = ins_q.op;
  assign alu_a       = ins_q.lui ? '0 : rs1_fwd;
  assign alu_b       = (ins_q.use_imm || ins_q.lui) ? ins_q.imm : rs2_fwd;
endmodule

// File: tb/tb_id_ex_alu_issue.sv
// tb_id_ex_alu_issue: scoreboard bench with a spec-level model of decode, handshake and forwarding
module tb_id_ex_alu_issue;
  logic        clk, rst_n, in_valid, in_ready, use_imm, funct7b5, flush, ex_stall;
  logic [31:0] rs1_data, rs2_data, imm, exm_data, mwb_data, alu_a, alu_b;
  logic [4:0]  rs1_addr, rs2_addr, rd_addr, exm_rd, mwb_rd, out_rd;
  logic [1:0]  alu_class;
  logic [2:0]  funct3;
  logic        exm_wr, mwb_wr, out_valid, out_illegal;
  logic [3:0]  alu_op;

  id_ex_alu_issue dut (
    .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
    .rs1_data(rs1_data), .rs2_data(rs2_data), .rs1_addr(rs1_addr), .rs2_addr(rs2_addr),
    .rd_addr(rd_addr), .imm(imm), .use_imm(use_imm), .alu_class(alu_class),
    .funct3(funct3), .funct7b5(funct7b5), .flush(flush), .ex_stall(ex_stall),
    .exm_wr(exm_wr), .exm_rd(exm_rd), .exm_data(exm_data),
    .mwb_wr(mwb_wr), .mwb_rd(mwb_rd), .mwb_data(mwb_data),
    .out_valid(out_valid), .out_rd(out_rd), .out_illegal(out_illegal),
    .alu_a(alu_a), .alu_b(alu_b), .alu_op(alu_op)
  );

  typedef struct {
    logic [4:0]  rd, ra, rb;
    logic [31:0] da, db, imm;
    logic        ui, lui, ill;
    logic [3:0]  op;
  } exp_t;

  exp_t sb[$];
  int   n_cmp = 0;
  int   n_bad = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [4:0] ref_decode(input logic [1:0] cls, input logic [2:0] f3,
                                            input logic f7, input logic ui);
    if (cls == 2'b01) return 5'b0_0110;
    if (cls != 2'b10) return 5'b0_0010;
    case (f3)
      3'd0: return (f7 && !ui) ? 5'b0_0110 : 5'b0_0010;
      3'd1: return 5'b0_1101;
      3'd2, 3'd3: return 5'b0_0111;
      3'd4: return 5'b1_0000;
      3'd5: return f7 ? 5'b0_1000 : 5'b0_1110;
      3'd6: return 5'b0_0001;
      default: return 5'b0_0000;
    endcase
  endfunction

  function automatic logic [31:0] ref_src(input logic [4:0] a, input logic [31:0] d);
    if (a == 0) return d;
    if (exm_wr && exm_rd == a) return exm_data;
    if (mwb_wr && mwb_rd == a) return mwb_data;
    return d;
  endfunction

  // monitor: checks handshake and the front of the scoreboard each cycle, then retires/enqueues
  always @(negedge clk) begin
    if (rst_n) begin
      logic exp_rdy;
      exp_t e;
      exp_rdy = (sb.size() == 0 || !ex_stall) && !flush;
      chk("in_ready", 32'(in_ready), 32'(exp_rdy));
      chk("out_valid", 32'(out_valid), 32'(sb.size() != 0));
      if (sb.size() != 0 && out_valid) begin
        e = sb[0];
        chk("out_rd", 32'(out_rd), 32'(e.rd));
        chk("alu_op", 32'(alu_op), 32'(e.op));
        chk("out_illegal", 32'(out_illegal), 32'(e.ill));
        chk("alu_a", alu_a, e.lui ? 32'd0 : ref_src(e.ra, e.da));
        chk("alu_b", alu_b, (e.ui || e.lui) ? e.imm : ref_src(e.rb, e.db));
      end
      if (sb.size() != 0 && (!ex_stall || flush)) void'(sb.pop_front());
      if (in_valid && exp_rdy) begin
        logic [4:0] d;
        d = ref_decode(alu_class, funct3, funct7b5, use_imm);
        e.rd = rd_addr; e.ra = rs1_addr; e.rb = rs2_addr;
        e.da = rs1_data; e.db = rs2_data; e.imm = imm;
        e.ui = use_imm; e.lui = (alu_class == 2'b11);
        e.ill = d[4]; e.op = d[3:0];
        sb.push_back(e);
      end
    end
  end

  task automatic idle();
    in_valid = 0; flush = 0; ex_stall = 0; exm_wr = 0; mwb_wr = 0;
    exm_rd = 0; mwb_rd = 0; exm_data = 0; mwb_data = 0;
    rs1_addr = 0; rs2_addr = 0; rd_addr = 0; rs1_data = 0; rs2_data = 0;
    imm = 0; use_imm = 0; alu_class = 0; funct3 = 0; funct7b5 = 0;
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic rand_inputs();
    in_valid = ($urandom_range(0, 9) < 7);
    flush = ($urandom_range(0, 9) == 0);
    ex_stall = ($urandom_range(0, 9) < 3);
    rs1_addr = 5'($urandom_range(0, 7)); rs2_addr = 5'($urandom_range(0, 7));
    rd_addr = 5'($urandom); rs1_data = $urandom; rs2_data = $urandom; imm = $urandom;
    use_imm = 1'($urandom); alu_class = 2'($urandom); funct3 = 3'($urandom); funct7b5 = 1'($urandom);
    exm_wr = 1'($urandom); exm_rd = 5'($urandom_range(0, 7)); exm_data = $urandom;
    mwb_wr = 1'($urandom); mwb_rd = 5'($urandom_range(0, 7)); mwb_data = $urandom;
  endtask

  initial begin
    idle();
    rst_n = 0;
    #2;
    chk("rst out_valid", 32'(out_valid), 0);
    chk("rst alu_op", 32'(alu_op), 0);
    chk("rst out_rd", 32'(out_rd), 0);
    chk("rst out_illegal", 32'(out_illegal), 0);
    chk("rst alu_a", alu_a, 0);
    chk("rst alu_b", alu_b, 0);
    step(); step();
    rst_n = 1;
    step();
    // SUB with register operands
    alu_class = 2'b10; funct3 = 0; funct7b5 = 1; use_imm = 0; in_valid = 1;
    rs1_addr = 1; rs2_addr = 2; rs1_data = 7; rs2_data = 3; rd_addr = 9;
    step();
    idle();
    @(negedge clk);
    chk("sub valid", 32'(out_valid), 1);
    chk("sub op", 32'(alu_op), 32'h6);
    chk("sub a", alu_a, 7);
    chk("sub b", alu_b, 3);
    // forwarding priority while stalled, then reset mid-stall
    step();
    alu_class = 2'b10; funct3 = 6; in_valid = 1; rs1_addr = 5; rs1_data = 1; rs2_addr = 6; rd_addr = 4;
    step();
    rd_addr = 11; ex_stall = 1;
    exm_wr = 1; exm_rd = 5; exm_data = 32'hAA; mwb_wr = 1; mwb_rd = 5; mwb_data = 32'hBB;
    @(negedge clk);
    chk("stall in_ready", 32'(in_ready), 0);
    chk("fwd exm", alu_a, 32'hAA);
    step();
    exm_wr = 0;
    @(negedge clk);
    chk("fwd mwb", alu_a, 32'hBB);
    chk("stall rd held", 32'(out_rd), 4);
    step();
    mwb_data = 32'hCC;
    @(negedge clk);
    chk("fwd mwb live", alu_a, 32'hCC);
    step();
    rst_n = 0;
    #1;
    chk("async rst valid", 32'(out_valid), 0);
    chk("async rst op", 32'(alu_op), 0);
    sb.delete();
    idle();
    step();
    rst_n = 1;
    @(negedge clk);
    chk("post rst ready", 32'(in_ready), 1);
    // x0 never forwards
    step();
    in_valid = 1; alu_class = 0; rs2_addr = 0; rs2_data = 0; rs1_addr = 3; rs1_data = 32'h10;
    step();
    idle();
    exm_wr = 1; exm_rd = 0; exm_data = 32'h55;
    @(negedge clk);
    chk("x0 b", alu_b, 0);
    // flush discards a simultaneous instruction, then illegal XOR
    step();
    idle();
    in_valid = 1; flush = 1; alu_class = 2'b10;
    step();
    idle();
    @(negedge clk);
    chk("flush valid", 32'(out_valid), 0);
    step();
    in_valid = 1; alu_class = 2'b10; funct3 = 4; rd_addr = 7;
    step();
    idle();
    @(negedge clk);
    chk("xor illegal", 32'(out_illegal), 1);
    chk("xor op", 32'(alu_op), 0);
    // randomized traffic
    for (int i = 0; i < 3000; i++) begin
      step();
      rand_inputs();
    end
    step();
    idle();
    repeat (4) step();
    chk("drain", 32'(sb.size()), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
